// File: rtl/exec_inject.sv
// Immediate-instruction injector: presents host-forced and EXEC'd instruction words to the SM,
// holding across stalls, with one pending slot and a sticky overflow flag.
module exec_inject #(
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               host_wr,
  input  logic [INSTR_W-1:0] host_instr,
  input  logic               exec_req,
  input  logic [INSTR_W-1:0] exec_instr,
  input  logic               stalled,
  input  logic               clr_dropped,
  output logic               imm,
  output logic [INSTR_W-1:0] instr_out,
  output logic               busy,
  output logic               pending,
  output logic               dropped,
  output logic [CNT_W-1:0]   issued_cnt
);

  typedef enum logic [1:0] {IDLE, ACTIVE, ACTIVE_PEND} state_t;

  state_t             r_state;
  logic [INSTR_W-1:0] r_act;
  logic [INSTR_W-1:0] r_pend;
  logic               r_dropped;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_act_vld;
  logic               w_pend_vld;
  logic               w_done;
  logic [1:0]         w_n;
  logic [INSTR_W-1:0] w_s0;
  logic [INSTR_W-1:0] w_s1;
  logic               w_drop;

  assign w_act_vld  = (r_state != IDLE);
  assign w_pend_vld = (r_state == ACTIVE_PEND);
  assign w_done     = w_act_vld & ~stalled;

  // Slots behave as a two-entry queue: retire the head on completion, then
  // append exec_req before host_wr so the program's EXEC runs first.
  always_comb begin
    w_drop = 1'b0;
    w_s0   = r_act;
    w_s1   = r_pend;
    w_n    = {1'b0, w_act_vld} + {1'b0, w_pend_vld} - {1'b0, w_done};
    if (w_done && w_pend_vld) w_s0 = r_pend;
    if (exec_req) begin
      case (w_n)
        2'd0:    begin w_s0 = exec_instr; w_n = 2'd1; end
        2'd1:    begin w_s1 = exec_instr; w_n = 2'd2; end
        default: w_drop = 1'b1;
      endcase
    end
    if (host_wr) begin
      case (w_n)
        2'd0:    begin w_s0 = host_instr; w_n = 2'd1; end
        2'd1:    begin w_s1 = host_instr; w_n = 2'd2; end
        default: w_drop = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    r_pend <= w_s1;
    if (reset) begin
      r_state   <= IDLE;
      r_act     <= '0;
      r_dropped <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (w_n)
        2'd0:    r_state <= IDLE;
        2'd1:    r_state <= ACTIVE;
        default: r_state <= ACTIVE_PEND;
      endcase
      r_act     <= w_s0;
      r_dropped <= w_drop | (r_dropped & ~clr_dropped);
      r_cnt     <= r_cnt + CNT_W'(w_done);
    end
  end

  assign imm        = w_act_vld;
  assign busy       = w_act_vld;
  assign pending    = w_pend_vld;
  assign instr_out  = r_act;
  assign dropped    = r_dropped;
  assign issued_cnt = r_cnt;

endmodule

// File: tb/tb_exec_inject.sv
// Bench for exec_inject: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_exec_inject;

  localparam int INSTR_W = 16;
  localparam int CNT_W   = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               host_wr;
  logic [INSTR_W-1:0] host_instr;
  logic               exec_req;
  logic [INSTR_W-1:0] exec_instr;
  logic               stalled;
  logic               clr_dropped;
  logic               imm;
  logic [INSTR_W-1:0] instr_out;
  logic               busy;
  logic               pending;
  logic               dropped;
  logic [CNT_W-1:0]   issued_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  exec_inject #(.INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .host_wr(host_wr), .host_instr(host_instr),
    .exec_req(exec_req), .exec_instr(exec_instr), .stalled(stalled),
    .clr_dropped(clr_dropped), .imm(imm), .instr_out(instr_out), .busy(busy),
    .pending(pending), .dropped(dropped), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a bounded FIFO of at most two words.
  logic [INSTR_W-1:0] mq[$];
  logic [INSTR_W-1:0] mlast = '0;
  int                 mcnt  = 0;
  bit                 mdrop = 1'b0;
  bit                 mdrop_now;

  always @(posedge clk) begin
    mdrop_now = 1'b0;
    if (reset) begin
      mq.delete();
      mcnt  = 0;
      mdrop = 1'b0;
      mlast = '0;
    end else begin
      if (mq.size() != 0 && !stalled) begin
        void'(mq.pop_front());
        mcnt = (mcnt + 1) % (1 << CNT_W);
      end
      if (exec_req) begin
        if (mq.size() < 2) mq.push_back(exec_instr); else mdrop_now = 1'b1;
      end
      if (host_wr) begin
        if (mq.size() < 2) mq.push_back(host_instr); else mdrop_now = 1'b1;
      end
      if (mdrop_now) mdrop = 1'b1;
      else if (clr_dropped) mdrop = 1'b0;
      if (mq.size() != 0) mlast = mq[0];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model.imm",     32'(imm),        32'(mq.size() != 0));
      chk("model.busy",    32'(busy),       32'(mq.size() != 0));
      chk("model.pending", 32'(pending),    32'(mq.size() == 2));
      chk("model.instr",   32'(instr_out),  32'(mlast));
      chk("model.dropped", 32'(dropped),    32'(mdrop));
      chk("model.cnt",     32'(issued_cnt), 32'(mcnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    exec_req = 1'b0; host_wr = 1'b0; clr_dropped = 1'b0; reset = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; stalled = 1'b0;
    tick();
  endtask

  task automatic host(input logic [INSTR_W-1:0] w);
    host_wr = 1'b1; host_instr = w;
  endtask

  task automatic exec(input logic [INSTR_W-1:0] w);
    exec_req = 1'b1; exec_instr = w;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; host_wr = 1'b0; host_instr = '0; exec_req = 1'b0;
    exec_instr = '0; stalled = 1'b0; clr_dropped = 1'b0;
    tick();
    chk_en = 1'b1;
    at_neg();
    chk("rst.imm", 32'(imm), 0);
    chk("rst.pending", 32'(pending), 0);
    chk("rst.dropped", 32'(dropped), 0);
    chk("rst.cnt", 32'(issued_cnt), 0);
    chk("rst.instr", 32'(instr_out), 0);

    // Basic inject
    do_reset();
    host(16'hE001); tick(); at_neg();
    chk("basic.imm", 32'(imm), 1);
    chk("basic.instr", 32'(instr_out), 32'hE001);
    tick(); at_neg();
    chk("basic.idle", 32'(imm), 0);
    chk("basic.cnt", 32'(issued_cnt), 1);
    chk("basic.retain", 32'(instr_out), 32'hE001);

    // Stall hold for cycles 2-5, completes in cycle 6
    do_reset();
    host(16'h2020); stalled = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk("stall.imm", 32'(imm), 1);
      chk("stall.instr", 32'(instr_out), 32'h2020);
      chk("stall.cnt", 32'(issued_cnt), 0);
      tick();
    end
    stalled = 1'b0; at_neg();
    chk("stall.c6imm", 32'(imm), 1);
    tick(); at_neg();
    chk("stall.done", 32'(imm), 0);
    chk("stall.cnt1", 32'(issued_cnt), 1);

    // Back-to-back with pending
    do_reset();
    stalled = 1'b1;
    host(16'hA042); tick();
    host(16'hE081); tick(); at_neg();
    chk("b2b.pending", 32'(pending), 1);
    chk("b2b.instr0", 32'(instr_out), 32'hA042);
    stalled = 1'b0; tick(); at_neg();
    chk("b2b.imm", 32'(imm), 1);
    chk("b2b.instr1", 32'(instr_out), 32'hE081);
    chk("b2b.pend0", 32'(pending), 0);
    tick(); at_neg();
    chk("b2b.cnt", 32'(issued_cnt), 2);
    chk("b2b.idle", 32'(imm), 0);

    // Priority, overflow, set-vs-clear, clear
    do_reset();
    stalled = 1'b1;
    exec(16'h6001); host(16'h6002); tick(); at_neg();
    chk("prio.first", 32'(instr_out), 32'h6001);
    chk("prio.pending", 32'(pending), 1);
    chk("prio.nodrop", 32'(dropped), 0);
    host(16'h7777); tick(); at_neg();
    chk("ovf.dropped", 32'(dropped), 1);
    chk("ovf.keep", 32'(instr_out), 32'h6001);
    exec(16'h7778); clr_dropped = 1'b1; tick(); at_neg();
    chk("ovf.setwins", 32'(dropped), 1);
    clr_dropped = 1'b1; tick(); at_neg();
    chk("ovf.clear", 32'(dropped), 0);
    stalled = 1'b0; tick(); at_neg();
    chk("prio.second", 32'(instr_out), 32'h6002);
    chk("prio.cnt1", 32'(issued_cnt), 1);
    tick(); at_neg();
    chk("prio.cnt2", 32'(issued_cnt), 2);

    // Reset mid-hold with pending full and dropped set
    do_reset();
    stalled = 1'b1;
    host(16'h1111); tick();
    host(16'h2222); tick();
    exec(16'h3333); tick(); at_neg();
    chk("mid.pre", 32'(dropped), 1);
    reset = 1'b1; tick(); at_neg();
    chk("mid.imm", 32'(imm), 0);
    chk("mid.pending", 32'(pending), 0);
    chk("mid.dropped", 32'(dropped), 0);
    chk("mid.cnt", 32'(issued_cnt), 0);
    chk("mid.instr", 32'(instr_out), 0);

    // Counter wrap after 256 completions
    do_reset();
    for (int i = 0; i < 256; i++) begin
      host(16'(i)); tick();
    end
    at_neg();
    chk("wrap.255", 32'(issued_cnt), 255);
    chk("wrap.last", 32'(instr_out), 32'h00FF);
    tick(); at_neg();
    chk("wrap.zero", 32'(issued_cnt), 0);
    chk("wrap.idle", 32'(imm), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_inject.md
Name: exec_inject

Overview:
- Initiator side of the state machine's immediate-instruction path. Generates `imm` and the forced instruction word consumed by the SM's PC/decode logic.
- Two sources feed it:
  - host writes to the SMx_INSTR register (forced instructions);
  - OUT EXEC / MOV EXEC results from the running program (EXEC'd instructions).
- Holds an instruction across SM stalls until it completes.
- Buffers one extra request and flags any request lost to overflow.

Parameters:
- INSTR_W, 16, instruction word width.
- CNT_W, 8, width of the issued-instruction counter.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- host_wr  input  1  one-cycle strobe: host wrote SMx_INSTR.
- host_instr  input  INSTR_W  instruction written by host; valid with host_wr.
- exec_req  input  1  one-cycle strobe: current SM instruction is OUT/MOV with EXEC destination.
- exec_instr  input  INSTR_W  instruction word to execute; valid with exec_req.
- stalled  input  1  SM reports the instruction presented this cycle has not completed.
- clr_dropped  input  1  clears the dropped flag.
- imm  output  1  forced/EXEC'd instruction presented this cycle.
- instr_out  output  INSTR_W  instruction presented; valid when imm=1.
- busy  output  1  active slot occupied (equals imm).
- pending  output  1  second slot occupied.
- dropped  output  1  sticky: a request was discarded.
- issued_cnt  output  CNT_W  count of completed injected instructions, wraps.

Behaviour:
- Reset: active slot empty, pending slot empty, imm=0, busy=0, pending=0, dropped=0, issued_cnt=0, instr_out=0. Reset applied mid-hold discards both slots without counting.
- States:
  - IDLE: no slot occupied.
  - ACTIVE: active slot presented, imm=1.
  - ACTIVE_PEND: active slot presented and pending slot full.
- Latency: a request accepted at edge N is presented from cycle N+1 (imm=1, instr_out=word). No combinational path from host_wr or exec_req to imm.
- Completion: a cycle with imm=1 and stalled=0 completes the active instruction at the next edge. On that edge issued_cnt increments (modulo 2^CNT_W).
- Stall hold: while imm=1 and stalled=1, instr_out and imm hold unchanged indefinitely. This does not depend on penable; imm executes even when the SM is disabled.
- Arrivals into the slots (this edge's accepted requests, ordered exec_req then host_wr):
  - The first arrival goes to the active slot if it is empty or completing; otherwise it goes to pending.
  - The second arrival goes to the next free slot.
  - With no free slot, the request is discarded and dropped is set.
- Completion with pending full: the pending word moves to active at the completion edge, so imm stays 1 with no bubble.
- Simultaneous exec_req and host_wr: exec_req wins the earlier slot, because it originates from the executing program and must run next cycle.
- dropped:
  - Set by any discard.
  - Cleared by clr_dropped.
  - When set and clear coincide, set wins.
- instr_out retains its last value when imm=0.
- No arithmetic beyond the wrapping counter. Instruction words pass through unmodified.

Test Plan:
- Basic inject: host_wr with 0xE001 at edge 1, stalled=0 → imm=1 with instr_out=0xE001 in cycle 2; imm=0 in cycle 3; issued_cnt=1.
- Stall hold: host_wr 0x2020, stalled=1 for cycles 2–5 then 0 → imm and instr_out=0x2020 held for cycles 2–6; issued_cnt increments once, after cycle 6.
- Back-to-back: host_wr 0xA042, then host_wr 0xE081 the next cycle while stalled=1 → pending=1; once the stall drops, 0xE081 is presented the following cycle with no imm gap; issued_cnt=2.
- Priority and overflow:
  - Same cycle exec_req 0x6001 and host_wr 0x6002 from IDLE → 0x6001 presented first, then 0x6002.
  - A third request while both slots are full → discarded, dropped=1.
  - clr_dropped → dropped=0.
- Reset mid-operation: reset asserted while holding a stalled instruction with pending full → next cycle imm=0, pending=0, dropped=0, issued_cnt=0.
- Counter wrap: 256 completed injections → issued_cnt returns to 0.
